// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  // Which requester owns the shared port in a given cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_GFX  = 2'd2
  } owner_t;

  // One command as presented to the memory.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WE_W-1:0]   we;
    logic [DATA_W-1:0] din;
  } mem_cmd_t;

  // A command with no byte enables is a read.
  function automatic logic is_read(input logic [WE_W-1:0] we);
    return (we == '0);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared data-memory port.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  // CPU data port
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WE_W-1:0]   cpu_we;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_dout;

  // Graphics pixel port
  logic              gfx_req;
  logic [ADDR_W-1:0] gfx_addr;
  logic [WE_W-1:0]   gfx_we;
  logic [DATA_W-1:0] gfx_din;
  logic              gfx_gnt;
  logic              gfx_rvalid;
  logic [DATA_W-1:0] gfx_dout;

  // Shared memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [WE_W-1:0]   mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Requesters and memory model side
  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_din,
    input  cpu_stall, cpu_rvalid, cpu_dout,
    output gfx_req, gfx_addr, gfx_we, gfx_din,
    input  gfx_gnt, gfx_rvalid, gfx_dout,
    input  mem_addr, mem_we, mem_re, mem_din,
    output mem_dout
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_din,
    output cpu_stall, cpu_rvalid, cpu_dout,
    input  gfx_req, gfx_addr, gfx_we, gfx_din,
    output gfx_gnt, gfx_rvalid, gfx_dout,
    output mem_addr, mem_we, mem_re, mem_din,
    input  mem_dout
  );

endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Read tag delay line: remembers who issued each read so the returning
// data RD_LAT cycles later can be steered to the right requester.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  owner_t in_owner,
  output logic   out_valid,
  output owner_t out_owner
);

  logic [RD_LAT:1]      vld_pipe;
  logic [RD_LAT:1][1:0] own_pipe;

  // Shift the {valid, owner} tag one stage per cycle; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      own_pipe[1] <= in_owner;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[RD_LAT];
  assign out_owner = owner_t'(own_pipe[RD_LAT]);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the CPU and the graphics engine.
// CPU has fixed priority; a starvation counter forces a graphics slot
// after STARVE_MAX consecutive denials. Commands issue in the grant cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       starved;
  logic       gfx_win;
  logic       cpu_win;
  owner_t     owner;
  mem_cmd_t   cmd;
  logic       tag_vld;
  owner_t     tag_own;

  assign starved = (starve_cnt == STARVE_LIM);

  // Grant: CPU first unless gfx has been starved long enough; nothing while in reset.
  always_comb begin
    gfx_win = ~rst & bus.gfx_req & (~bus.cpu_req | starved);
    cpu_win = ~rst & bus.cpu_req & ~gfx_win;
  end

  // Command mux: the winner drives the shared port, idle port is all zeros.
  always_comb begin
    owner = OWN_NONE;
    cmd   = '0;
    if (cpu_win) begin
      owner = OWN_CPU;
      cmd   = '{addr: bus.cpu_addr, we: bus.cpu_we, din: bus.cpu_din};
    end else if (gfx_win) begin
      owner = OWN_GFX;
      cmd   = '{addr: bus.gfx_addr, we: bus.gfx_we, din: bus.gfx_din};
    end
  end

  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_we    = cmd.we;
  assign bus.mem_din   = cmd.din;
  assign bus.mem_re    = (owner != OWN_NONE) & is_read(cmd.we);

  assign bus.cpu_stall = bus.cpu_req & ~cpu_win & ~rst;
  assign bus.gfx_gnt   = gfx_win;

  // Count consecutive denied gfx cycles; any grant or idle gfx cycle restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (bus.gfx_req & ~gfx_win) begin
      if (!starved) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.mem_re),
    .in_owner  (owner),
    .out_valid (tag_vld),
    .out_owner (tag_own)
  );

  // Read data is shared by both requesters; the tag says whose it is.
  assign bus.cpu_rvalid = tag_vld & (tag_own == OWN_CPU);
  assign bus.gfx_rvalid = tag_vld & (tag_own == OWN_GFX);
  assign bus.cpu_dout   = bus.mem_dout;
  assign bus.gfx_dout   = bus.mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two configurations driven with the same
// stimulus, compared cycle by cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int MAXC = 1024;

  typedef struct {
    logic        stall, gnt, re, crv, grv;
    logic [3:0]  we;
    logic [31:0] addr, din, cdo, gdo;
  } obs_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if ifa ();
  mem_port_arbiter_if ifb ();

  mem_port_arbiter #(.RD_LAT(2), .STARVE_MAX(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Current stimulus (shared by both DUTs)
  bit          s_rst, s_cr, s_gr;
  logic [31:0] s_ca, s_cd, s_ga, s_gd, s_md;
  logic [3:0]  s_cw, s_gw;

  // Model state per configuration
  int deny [2];
  bit exp_c [2][MAXC];
  bit exp_g [2][MAXC];
  obs_t oa, ob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: winner from the priority/starvation rule, reads return lat cycles later.
  task automatic model_check(input int d, input int sm, input int lat, input string nm, input obs_t o);
    bit gwin, cwin, re;
    logic [31:0] ea, ed;
    logic [3:0]  ew;
    gwin = !s_rst && s_gr && (!s_cr || deny[d] == sm);
    cwin = !s_rst && s_cr && !gwin;
    ea = cwin ? s_ca : gwin ? s_ga : 32'h0;
    ed = cwin ? s_cd : gwin ? s_gd : 32'h0;
    ew = cwin ? s_cw : gwin ? s_gw : 4'h0;
    re = (cwin || gwin) && (ew == 4'h0);
    if (s_rst)
      for (int i = cyc; i < MAXC; i++) begin
        exp_c[d][i] = 1'b0;
        exp_g[d][i] = 1'b0;
      end
    chk({nm, ".cpu_stall"}, 32'(o.stall), 32'(s_cr && !cwin && !s_rst));
    chk({nm, ".gfx_gnt"},   32'(o.gnt), 32'(gwin));
    chk({nm, ".mem_addr"},  o.addr, ea);
    chk({nm, ".mem_we"},    32'(o.we), 32'(ew));
    chk({nm, ".mem_din"},   o.din, ed);
    chk({nm, ".mem_re"},    32'(o.re), 32'(re));
    chk({nm, ".cpu_rvalid"}, 32'(o.crv), 32'(exp_c[d][cyc]));
    chk({nm, ".gfx_rvalid"}, 32'(o.grv), 32'(exp_g[d][cyc]));
    chk({nm, ".cpu_dout"},  o.cdo, s_md);
    chk({nm, ".gfx_dout"},  o.gdo, s_md);
    if (re && cyc + lat < MAXC) begin
      if (cwin) exp_c[d][cyc+lat] = 1'b1;
      else      exp_g[d][cyc+lat] = 1'b1;
    end
    if (s_rst) deny[d] = 0;
    else if (s_gr && !gwin) deny[d] = (deny[d] + 1 > sm) ? sm : deny[d] + 1;
    else deny[d] = 0;
  endtask

  // One clock cycle: drive, sample mid-cycle, check both DUTs, advance.
  task automatic do_cycle(input bit r, input bit cr, input logic [31:0] ca, input logic [3:0] cw,
                          input logic [31:0] cd, input bit gr, input logic [31:0] ga,
                          input logic [3:0] gw, input logic [31:0] gd, input logic [31:0] md);
    s_rst = r; s_cr = cr; s_ca = ca; s_cw = cw; s_cd = cd;
    s_gr = gr; s_ga = ga; s_gw = gw; s_gd = gd; s_md = md;
    rst = r;
    ifa.cpu_req = cr; ifa.cpu_addr = ca; ifa.cpu_we = cw; ifa.cpu_din = cd;
    ifa.gfx_req = gr; ifa.gfx_addr = ga; ifa.gfx_we = gw; ifa.gfx_din = gd; ifa.mem_dout = md;
    ifb.cpu_req = cr; ifb.cpu_addr = ca; ifb.cpu_we = cw; ifb.cpu_din = cd;
    ifb.gfx_req = gr; ifb.gfx_addr = ga; ifb.gfx_we = gw; ifb.gfx_din = gd; ifb.mem_dout = md;
    @(negedge clk);
    oa = '{ifa.cpu_stall, ifa.gfx_gnt, ifa.mem_re, ifa.cpu_rvalid, ifa.gfx_rvalid,
           ifa.mem_we, ifa.mem_addr, ifa.mem_din, ifa.cpu_dout, ifa.gfx_dout};
    ob = '{ifb.cpu_stall, ifb.gfx_gnt, ifb.mem_re, ifb.cpu_rvalid, ifb.gfx_rvalid,
           ifb.mem_we, ifb.mem_addr, ifb.mem_din, ifb.cpu_dout, ifb.gfx_dout};
    model_check(0, 4, 2, "a", oa);
    model_check(1, 1, 1, "b", ob);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      do_cycle(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, $urandom);
  endtask

  logic [9:0] pat_ga, pat_gb, pat_sa;
  logic [4:0] rv_ga, rv_ca, rv_gb, rv_cb, pat_clr;

  initial begin
    deny[0] = 0; deny[1] = 0;
    for (int i = 0; i < MAXC; i++) begin
      exp_c[0][i] = 0; exp_g[0][i] = 0; exp_c[1][i] = 0; exp_g[1][i] = 0;
    end

    // Reset state, including requests held high while in reset
    do_cycle(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    do_cycle(1, 1, 32'h1234, 4'h0, 32'h0, 1, 32'h5678, 4'hF, 32'h9, 32'h0);
    idle(2);

    // CPU-only read returning 0xDEADBEEF
    do_cycle(0, 1, 32'h10000008, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    do_cycle(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF);
    do_cycle(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF);
    idle(1);

    // Reset in the cycle after a CPU read: no rvalid ever
    do_cycle(0, 1, 32'h10000004, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    do_cycle(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    idle(4);

    // Contention for 10 cycles
    pat_ga = '0; pat_gb = '0; pat_sa = '0;
    for (int i = 0; i < 10; i++) begin
      do_cycle(0, 1, 32'h100 + 32'(i), 4'hF, $urandom, 1, 32'h200 + 32'(i), 4'h3, $urandom, $urandom);
      pat_ga = {pat_ga[8:0], oa.gnt};
      pat_sa = {pat_sa[8:0], oa.stall};
      pat_gb = {pat_gb[8:0], ob.gnt};
    end
    chk("contention_gnt_a",   32'(pat_ga), 32'(10'b0000100001));
    chk("contention_stall_a", 32'(pat_sa), 32'(10'b0000100001));
    chk("contention_gnt_b",   32'(pat_gb), 32'(10'b0101010101));
    idle(1);

    // Interleaved reads: gfx then CPU
    rv_ga = '0; rv_ca = '0; rv_gb = '0; rv_cb = '0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      do_cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h20, 4'h0, 32'h0, $urandom);
      else if (i == 1) do_cycle(0, 1, 32'h40, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, $urandom);
      else             idle(1);
      rv_ga = {rv_ga[3:0], oa.grv}; rv_ca = {rv_ca[3:0], oa.crv};
      rv_gb = {rv_gb[3:0], ob.grv}; rv_cb = {rv_cb[3:0], ob.crv};
    end
    chk("interleave_gfx_rv_a", 32'(rv_ga), 32'(5'b00100));
    chk("interleave_cpu_rv_a", 32'(rv_ca), 32'(5'b00010));
    chk("interleave_gfx_rv_b", 32'(rv_gb), 32'(5'b01000));
    chk("interleave_cpu_rv_b", 32'(rv_cb), 32'(5'b00100));

    // Graphics write pass-through
    do_cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h1F000000, 4'b0011, 32'h0000ABCD, 32'h0);
    chk("wr_gnt", 32'(oa.gnt), 32'd1);
    chk("wr_mem_din", oa.din, 32'h0000ABCD);
    idle(3);

    // Starve counter clears when gfx_req drops
    for (int i = 0; i < 3; i++)
      do_cycle(0, 1, 32'h300, 4'hF, 32'h1, 1, 32'h400, 4'hF, 32'h2, 32'h0);
    do_cycle(0, 1, 32'h300, 4'hF, 32'h1, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    pat_clr = '0;
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 1, 32'h300, 4'hF, 32'h1, 1, 32'h400, 4'hF, 32'h2, 32'h0);
      pat_clr = {pat_clr[3:0], oa.gnt};
    end
    chk("starve_clear_gnt_a", 32'(pat_clr), 32'(5'b00001));
    idle(2);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      bit r, cr, gr;
      logic [3:0] cw, gw;
      r  = ($urandom_range(0, 39) == 0);
      cr = $urandom_range(0, 99) < 70;
      gr = $urandom_range(0, 99) < 70;
      cw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      gw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      do_cycle(r, cr, $urandom, cw, $urandom, gr, $urandom, gw, $urandom, $urandom);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
